// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer state encoding, default transform size
// and the bit-reversal helper also used by the sample loader.
package fft_pkg;

    localparam int FFT_SIZE_DEFAULT = 16;
    localparam int LOG2_N           = $clog2(FFT_SIZE_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_V,
        ST_RD_U,
        ST_CALC,
        ST_WR_U,
        ST_WR_V,
        ST_DONE
    } fft_seq_state_e;

    // Reverse the low 'width' bits of value; upper result bits are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                                input int unsigned width);
        logic [31:0] rest;
        logic [31:0] result;
        rest   = value;
        result = '0;
        for (int unsigned i = 0; i < width; i++) begin
            result = {result[30:0], rest[0]};
            rest   = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_bfly_counter.sv
// Nested butterfly/group/stage counter for the radix-2 DIT walk.
// b counts within a group, g counts groups within a stage, s counts stages.
// The advance that retires the final butterfly wraps everything back to 0.
module fft_bfly_counter #(
    parameter int FFT_SIZE = 16,
    parameter int LOG2_N   = $clog2(FFT_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance_i,
    input  logic              clear_i,
    output logic              last_o,
    output logic [LOG2_N-1:0] s_o,
    output logic [LOG2_N-1:0] g_o,
    output logic [LOG2_N-1:0] b_o
);

    localparam logic [LOG2_N-1:0] ONE    = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] HALF   = LOG2_N'(FFT_SIZE / 2);
    localparam logic [LOG2_N-1:0] S_LAST = LOG2_N'(LOG2_N - 1);

    logic [LOG2_N-1:0] s_q;
    logic [LOG2_N-1:0] g_q;
    logic [LOG2_N-1:0] b_q;
    logic [LOG2_N-1:0] b_end;
    logic [LOG2_N-1:0] g_end;
    logic              b_wrap;
    logic              g_wrap;

    // Terminal values for the current stage: 2^s butterflies, N/2^(s+1) groups.
    always_comb begin
        b_end  = (ONE << s_q) - ONE;
        g_end  = (HALF >> s_q) - ONE;
        b_wrap = (b_q == b_end);
        g_wrap = (g_q == g_end);
        last_o = (s_q == S_LAST) && g_wrap && b_wrap;
    end

    // Counter registers; clear dominates advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (clear_i) begin
            s_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (advance_i) begin
            if (last_o) begin
                s_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end else if (b_wrap) begin
                b_q <= '0;
                if (g_wrap) begin
                    g_q <= '0;
                    s_q <= s_q + ONE;
                end else begin
                    g_q <= g_q + ONE;
                end
            end else begin
                b_q <= b_q + ONE;
            end
        end
    end

    assign s_o = s_q;
    assign g_o = g_q;
    assign b_o = b_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT control sequencer: walks every butterfly of every
// stage, driving RAM address/write enable, twiddle index and datapath strobes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i, counters held at 0
// RD_V    | present v address to RAM
// RD_U    | present u address, datapath captures rdata as v
// CALC    | hold u address, datapath captures rdata as u, registers results
// WR_U    | write u_new to u address
// WR_V    | write v_new to v address, then next butterfly or DONE
// DONE    | one-cycle completion pulse
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_SIZE = 16,
    parameter int LOG2_N   = $clog2(FFT_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              halt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LOG2_N-1:0] stage_o,
    output logic [LOG2_N-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic              wsel_o,
    output logic              cap_v_o,
    output logic              cap_u_o,
    output logic [LOG2_N-1:0] tw_addr_o
);

    localparam logic [LOG2_N-1:0] ONE   = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] S_MAX = LOG2_N'(LOG2_N - 1);

    fft_seq_state_e    state_q;
    fft_seq_state_e    state_d;
    logic              cnt_advance;
    logic              cnt_clear;
    logic              cnt_last;
    logic [LOG2_N-1:0] s_cnt;
    logic [LOG2_N-1:0] g_cnt;
    logic [LOG2_N-1:0] b_cnt;
    logic [LOG2_N-1:0] u_addr;
    logic [LOG2_N-1:0] v_addr;
    logic [LOG2_N-1:0] tw_val;

    // A butterfly retires on an unhalted WR_V; counters sit at 0 while idle.
    assign cnt_advance = (state_q == ST_WR_V) && !halt_i && !clear_i;
    assign cnt_clear   = clear_i || (state_q == ST_IDLE);

    fft_bfly_counter #(
        .FFT_SIZE (FFT_SIZE),
        .LOG2_N   (LOG2_N)
    ) u_bfly_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .advance_i (cnt_advance),
        .clear_i   (cnt_clear),
        .last_o    (cnt_last),
        .s_o       (s_cnt),
        .g_o       (g_cnt),
        .b_o       (b_cnt)
    );

    // Butterfly addresses and twiddle index from registered counters only.
    always_comb begin
        u_addr = (g_cnt << (s_cnt + ONE)) + b_cnt;
        v_addr = u_addr + (ONE << s_cnt);
        tw_val = b_cnt << (S_MAX - s_cnt);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear wins over everything, halt freezes busy states only.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RD_V;
                ST_RD_V: if (!halt_i) state_d = ST_RD_U;
                ST_RD_U: if (!halt_i) state_d = ST_CALC;
                ST_CALC: if (!halt_i) state_d = ST_WR_U;
                ST_WR_U: if (!halt_i) state_d = ST_WR_V;
                ST_WR_V: if (!halt_i) state_d = cnt_last ? ST_DONE : ST_RD_V;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Per-state outputs; halt gates only the strobes, never the addresses.
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        mem_addr_o = '0;
        mem_we_o   = 1'b0;
        wsel_o     = 1'b0;
        cap_v_o    = 1'b0;
        cap_u_o    = 1'b0;
        tw_addr_o  = '0;
        case (state_q)
            ST_RD_V: begin
                busy_o     = 1'b1;
                mem_addr_o = v_addr;
                tw_addr_o  = tw_val;
            end
            ST_RD_U: begin
                busy_o     = 1'b1;
                mem_addr_o = u_addr;
                tw_addr_o  = tw_val;
                cap_v_o    = !halt_i;
            end
            ST_CALC: begin
                busy_o     = 1'b1;
                mem_addr_o = u_addr;
                tw_addr_o  = tw_val;
                cap_u_o    = !halt_i;
            end
            ST_WR_U: begin
                busy_o     = 1'b1;
                mem_addr_o = u_addr;
                tw_addr_o  = tw_val;
                mem_we_o   = !halt_i;
            end
            ST_WR_V: begin
                busy_o     = 1'b1;
                mem_addr_o = v_addr;
                tw_addr_o  = tw_val;
                mem_we_o   = !halt_i;
                wsel_o     = 1'b1;
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign stage_o = s_cnt;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at FFT_SIZE 16 and 4.
module tb_fft_stage_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  addr;
        logic        we;
        logic        wsel;
        logic        cap_v;
        logic        cap_u;
        logic [3:0]  tw;
        logic [3:0]  stage;
        logic [31:0] cyc;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic start_s [2];
    logic halt_s  [2];
    logic clear_s [2];

    logic       busy16, done16, we16, wsel16, capv16, capu16;
    logic [3:0] stage16, addr16, tw16;
    logic       busy4, done4, we4, wsel4, capv4, capu4;
    logic [1:0] stage4, addr4, tw4;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t q16 [$];
    obs_t q4  [$];
    int   we_cnt [2];
    int   exp_we [2];

    always @(posedge clk) cyc <= cyc + 1;

    fft_stage_sequencer #(.FFT_SIZE(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .clear_i(clear_s[0]),
        .halt_i(halt_s[0]), .busy_o(busy16), .done_o(done16), .stage_o(stage16),
        .mem_addr_o(addr16), .mem_we_o(we16), .wsel_o(wsel16), .cap_v_o(capv16),
        .cap_u_o(capu16), .tw_addr_o(tw16)
    );

    fft_stage_sequencer #(.FFT_SIZE(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .clear_i(clear_s[1]),
        .halt_i(halt_s[1]), .busy_o(busy4), .done_o(done4), .stage_o(stage4),
        .mem_addr_o(addr4), .mem_we_o(we4), .wsel_o(wsel4), .cap_v_o(capv4),
        .cap_u_o(capu4), .tw_addr_o(tw4)
    );

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%0d done=%0d addr=%0d we=%0d wsel=%0d cap_v=%0d cap_u=%0d tw=%0d stage=%0d cyc=%0d",
                         o.busy, o.done, o.addr, o.we, o.wsel, o.cap_v, o.cap_u, o.tw, o.stage, o.cyc);
    endfunction

    function automatic obs_t mk(input int addr, input int we, input int wsel,
                                input int cv, input int cu, input int tw, input int s);
        obs_t e;
        e       = '0;
        e.busy  = 1'b1;
        e.addr  = 4'(addr);
        e.we    = 1'(we);
        e.wsel  = 1'(wsel);
        e.cap_v = 1'(cv);
        e.cap_u = 1'(cu);
        e.tw    = 4'(tw);
        e.stage = 4'(s);
        return e;
    endfunction

    function automatic void push_exp(input int w, input obs_t e);
        if (w == 0) q16.push_back(e);
        else        q4.push_back(e);
    endfunction

    // Reference walk: every butterfly of every stage, span = 2^s.
    function automatic void push_model(input int w, input int n, input int l);
        int span, u, v, tw;
        for (int s = 0; s < l; s++) begin
            span = 1 << s;
            for (int g = 0; g < n / (2 * span); g++) begin
                for (int b = 0; b < span; b++) begin
                    u  = g * 2 * span + b;
                    v  = u + span;
                    tw = b * (n / (2 * span));
                    push_exp(w, mk(v, 0, 0, 0, 0, tw, s));
                    push_exp(w, mk(u, 0, 0, 1, 0, tw, s));
                    push_exp(w, mk(u, 0, 0, 0, 1, tw, s));
                    push_exp(w, mk(u, 1, 0, 0, 0, tw, s));
                    push_exp(w, mk(v, 1, 1, 0, 0, tw, s));
                end
            end
        end
    endfunction

    task automatic mon(input int w, input obs_t o, input logic halt);
        obs_t e;
        bit   empty;
        if (o.busy && halt) begin
            checks++;
            if (o.we || o.cap_v || o.cap_u) begin
                errors++;
                $display("FAIL halt_gate dut%0d: got %s, expected no strobes", w, fmt(o));
            end
        end else if (o.busy || o.done) begin
            checks++;
            empty = (w == 0) ? (q16.size() == 0) : (q4.size() == 0);
            if (empty) begin
                errors++;
                $display("FAIL unexpected_output dut%0d: got %s, expected nothing", w, fmt(o));
            end else begin
                if (w == 0) e = q16.pop_front();
                else        e = q4.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL seq_step dut%0d: got %s, expected %s", w, fmt(o), fmt(e));
                end
            end
            if (o.we) we_cnt[w]++;
            if (o.done) begin
                checks++;
                if (we_cnt[w] != exp_we[w]) begin
                    errors++;
                    $display("FAIL we_count dut%0d: got %0d, expected %0d", w, we_cnt[w], exp_we[w]);
                end
            end
        end else begin
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL idle_outputs dut%0d: got %s, expected all zero", w, fmt(o));
            end
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        obs_t o;
        o.busy = busy16; o.done = done16; o.addr = addr16; o.we = we16;
        o.wsel = wsel16; o.cap_v = capv16; o.cap_u = capu16; o.tw = tw16;
        o.stage = done16 ? 4'd0 : stage16;
        o.cyc = done16 ? cyc : 0;
        mon(0, o, halt_s[0]);
    end

    always @(negedge clk) begin
        obs_t o;
        o.busy = busy4; o.done = done4; o.addr = {2'b00, addr4}; o.we = we4;
        o.wsel = wsel4; o.cap_v = capv4; o.cap_u = capu4; o.tw = {2'b00, tw4};
        o.stage = done4 ? 4'd0 : {2'b00, stage4};
        o.cyc = done4 ? cyc : 0;
        mon(1, o, halt_s[1]);
    end

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy16 : busy4;
    endfunction

    function automatic void flush(input int w);
        if (w == 0) q16.delete();
        else        q4.delete();
    endfunction

    task automatic check_idle_now(input int w, input string name);
        checks++;
        if (busy_of(w) !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d: got busy=%0d, expected 0", name, w, busy_of(w));
        end
    endtask

    // One transform, driven cycle by cycle from posedge+1.
    // abort_kind: 0 none, 1 clear_i, 2 async reset, applied in run cycle abort_cyc.
    task automatic run_fft(input int w, input int halt_at, input int halt_len,
                           input bit rand_halt, input int abort_kind,
                           input int abort_cyc, input bit hold);
        int   n, l, nb, p, extra, hcnt, cs;
        obs_t d;
        bit   h;
        n  = (w == 0) ? 16 : 4;
        l  = (w == 0) ? 4 : 2;
        nb = (n / 2) * l;
        exp_we[w] = 2 * nb;
        we_cnt[w] = 0;
        push_model(w, n, l);
        start_s[w] = 1'b1;
        halt_s[w]  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cs = cyc;
        if (!hold) start_s[w] = 1'b0;
        p = 0; extra = 0; hcnt = 0;
        while (p < 5 * nb) begin
            if (abort_kind != 0 && (1 + p + extra) == abort_cyc) begin
                if (abort_kind == 1) begin
                    halt_s[w]  = 1'b1;
                    clear_s[w] = 1'b1;
                    @(posedge clk); #1;
                    clear_s[w] = 1'b0;
                    halt_s[w]  = 1'b0;
                    flush(w);
                    check_idle_now(w, "clear_idle");
                end else begin
                    halt_s[w] = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    flush(w);
                    check_idle_now(w, "reset_idle");
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end
                start_s[w] = 1'b0;
                return;
            end
            h = 1'b0;
            if (p == halt_at && hcnt < halt_len) begin
                h = 1'b1;
                hcnt++;
            end else if (rand_halt && $urandom_range(0, 3) == 0) begin
                h = 1'b1;
            end
            halt_s[w] = h;
            @(posedge clk); #1;
            if (h) extra++;
            else   p++;
        end
        halt_s[w] = 1'($urandom_range(0, 1));
        d      = '0;
        d.done = 1'b1;
        d.cyc  = cs + 5 * nb + extra;
        push_exp(w, d);
        @(posedge clk); #1;
        halt_s[w] = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            halt_s[i]  = 1'b0;
            clear_s[i] = 1'b0;
            we_cnt[i]  = 0;
            exp_we[i]  = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_fft(0, -1, 0, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run_fft(0, 3, 3, 1'b0, 0, 0, 1'b0);
        run_fft(0, -1, 0, 1'b0, 1, 50, 1'b0);
        run_fft(0, -1, 0, 1'b0, 0, 0, 1'b0);
        run_fft(0, -1, 0, 1'b0, 2, 77, 1'b0);
        run_fft(0, -1, 0, 1'b0, 0, 0, 1'b1);
        run_fft(0, -1, 0, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) run_fft(0, -1, 0, 1'b1, 0, 0, 1'b0);
        run_fft(1, -1, 0, 1'b0, 0, 0, 1'b0);
        run_fft(1, 3, 2, 1'b0, 0, 0, 1'b0);
        run_fft(1, -1, 0, 1'b1, 0, 0, 1'b0);
        run_fft(1, -1, 0, 1'b0, 1, 7, 1'b0);
        run_fft(1, -1, 0, 1'b0, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q16.size() != 0) begin
            errors++;
            $display("FAIL drain dut0: got %0d pending, expected 0", q16.size());
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL drain dut1: got %0d pending, expected 0", q4.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer for the in-place radix-2 DIT FFT datapath. On `start_i` it walks every butterfly of every stage and drives four things: the single-port data RAM address and write enable, the twiddle ROM address, and the capture/select strobes of the butterfly datapath. It sits between the sample-loading logic, which fills RAM in bit-reversed order, and the output streamer, which it notifies with `done_o`. It owns no data; all complex arithmetic stays in the datapath.

## Interface
- `FFT_SIZE`, default 16: transform length; power of two, ≥ 4.
- `LOG2_N`, default `$clog2(FFT_SIZE)`: derived; not overridden.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start request; level-sampled; accepted only in IDLE.
- `clear_i`  in  1  synchronous abort; return to IDLE at the next edge with no `done_o`.
- `halt_i`  in  1  freeze sequencing (datapath/RAM back-pressure).
- `busy_o`  out  1  high in every butterfly state.
- `done_o`  out  1  one-cycle pulse after the last write.
- `stage_o`  out  LOG2_N  current stage s.
- `mem_addr_o`  out  LOG2_N  RAM address.
- `mem_we_o`  out  1  RAM write enable.
- `wsel_o`  out  1  write-data select: 0 = u_new, 1 = v_new.
- `cap_v_o`  out  1  datapath latches RAM rdata as v.
- `cap_u_o`  out  1  datapath latches RAM rdata as u and registers u_new/v_new.
- `tw_addr_o`  out  LOG2_N  twiddle ROM index.

## Operation
- States: IDLE, RD_V, RD_U, CALC, WR_U, WR_V, DONE.
- IDLE → RD_V when `start_i`=1.
- Butterfly order: RD_V → RD_U → CALC → WR_U → WR_V.
- WR_V → RD_V of the next butterfly, or → DONE after the final butterfly.
- DONE → IDLE unconditionally. `start_i` is ignored in DONE and in every busy state.
- Counters, with s = stage, g = group, b = butterfly:
  - b runs 0..2^s−1 and advances on the WR_V exit.
  - g runs 0..(FFT_SIZE>>(s+1))−1 and advances when b wraps.
  - s advances when g wraps.
  - The final butterfly is s=LOG2_N−1, g=0, b=FFT_SIZE/2−1.
  - All counters clear in IDLE and on `clear_i`.
- Address arithmetic, unsigned, LOG2_N bits, no overflow by construction:
  - u = (g<<(s+1)) + b
  - v = u + (1<<s)
  - tw = b<<(LOG2_N−1−s)
- Per-state outputs:
  - RD_V: addr = v.
  - RD_U: addr = u, `cap_v_o`=1.
  - CALC: addr = u, `cap_u_o`=1.
  - WR_U: addr = u, `mem_we_o`=1, `wsel_o`=0.
  - WR_V: addr = v, `mem_we_o`=1, `wsel_o`=1.
  - IDLE, DONE: addr = 0, no strobes.
- `tw_addr_o` holds tw for the whole butterfly. It is 0 in IDLE and DONE.
- `halt_i`=1 holds the state and all counters. It combinationally forces `mem_we_o`, `cap_v_o` and `cap_u_o` to 0; the gated action occurs in the first unhalted cycle. `halt_i` has no effect in IDLE or DONE.
- `clear_i` takes priority over `halt_i` and over `start_i`.

## Timing
- Reset: state IDLE, all counters 0, every output 0.
- Reset mid-transform: immediate return to IDLE; RAM contents undefined; no `done_o`.
- RAM is synchronous, with 1-cycle read latency. Address presented in cycle k gives rdata in cycle k+1; hence `cap_v_o` in RD_U and `cap_u_o` in CALC.
- Latency without halts:
  - `start_i` sampled at edge 0, first RD_V in cycle 1.
  - 5 cycles per butterfly; FFT_SIZE/2·LOG2_N butterflies.
  - FFT_SIZE=16: last WR_V in cycle 160; `done_o` in cycle 161; IDLE in cycle 162. `busy_o` is high in cycles 1..160.
- Every halted cycle adds exactly one cycle to this latency.
- `stage_o`, `mem_addr_o` and `tw_addr_o` are registered or derived from registered state only; no input-to-output combinational path except the `halt_i` gating.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum `fft_seq_state_e`;
  - localparam `LOG2_N`;
  - the `bit_reverse` function, shared with the loader.
- Sub-module `fft_bfly_counter` holds the nested b/g/s counter. Its ports are `advance_i`, `clear_i`, `last_o`, `s_o`, `g_o`, `b_o`. The FSM and address math stay in the top module.

## Test plan
- Reset check: hold `rst_ni`=0, then release → all outputs 0, state IDLE.
- Single start, FFT_SIZE=16:
  - stage 0 address trace is 1,0,0,0,1 / 3,2,2,2,3 …; `tw_addr_o`=0;
  - stage 3 pairs are (0,8)..(7,15) with `tw_addr_o`=b;
  - `done_o` only in cycle 161, and exactly 64 `mem_we_o` pulses.
- Halt: `halt_i` high for 3 cycles during the first WR_U → no write while halted, one write after release, `done_o` in cycle 164.
- Clear: `clear_i` in cycle 50 → IDLE in cycle 51, `busy_o`=0, no `done_o`; a new `start_i` restarts at stage 0 with addr=1.
- Start while busy or in DONE: `start_i` held high throughout → ignored; the next run begins in cycle 163.
- FFT_SIZE=4: 4 butterflies → `done_o` in cycle 21; stage 1 `tw_addr_o` sequence 0,1.
